// File: rtl/match_game_ctrl.sv
// Card-matching game controller: log-on/off, level select, scramble, flip requests, BCD score, timer control.
// Optional per-player high-score table enabled by defining HIGH_SCORE_EN.
module match_game_ctrl #(
    parameter int IDX_W         = 3,
    parameter int PID_W         = 3,
    parameter int SCORE_DIGITS  = 2,
    parameter int LEVELS        = 3,
    parameter int PTS_PER_MATCH = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      logOn,
    input  logic [PID_W-1:0]          pIDin,
    input  logic                      isGuestIn,
    input  logic                      pwdPls,
    input  logic                      startPls,
    input  logic                      loadPls,
    input  logic [IDX_W-1:0]          indIn1,
    input  logic [IDX_W-1:0]          indIn2,
    input  logic                      isCorrect,
    input  logic                      timeOut,
    output logic [2:0]                state,
    output logic                      logOut,
    output logic [PID_W-1:0]          pIDout,
    output logic                      isGuestOut,
    output logic [4*SCORE_DIGITS-1:0] score,
    output logic [1:0]                lvl,
    output logic                      scramPls,
    output logic                      flipPls,
    output logic                      timerReconfig,
    output logic [IDX_W-1:0]          indOut1,
    output logic [IDX_W-1:0]          indOut2,
    output logic                      timerEn,
    output logic [4*SCORE_DIGITS-1:0] hiScore,
    output logic                      newHigh
);

    localparam int SW = 4 * SCORE_DIGITS;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MENU  = 3'd1,
        S_SCRAM = 3'd2,
        S_PLAY  = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic              log_q, log_d;
    logic [PID_W-1:0]  pid_q, pid_d;
    logic              guest_q, guest_d;
    logic [1:0]        lvl_q, lvl_d;
    logic [SW-1:0]     score_q, score_d, score_inc;
    logic [IDX_W-1:0]  ind1_q, ind1_d, ind2_q, ind2_d;
    logic              scram_q, scram_d;
    logic              flip_q, flip_d;
    logic              reconf_q, reconf_d;
    logic              ten_q, ten_d;
    logic              new_high_q, new_high_d;

`ifdef HIGH_SCORE_EN
    logic [SW-1:0]     hi_table [2**PID_W];
    logic              hs_wr;
`endif

    // Saturating BCD add; 4-bit wrap of (digit - 10) yields the corrected digit.
    always_comb begin
        logic [3:0] add;
        logic [4:0] dsum;
        logic [3:0] dadj;
        add       = 4'(PTS_PER_MATCH);
        score_inc = '0;
        dsum      = '0;
        dadj      = '0;
        for (int i = 0; i < SCORE_DIGITS; i++) begin
            dsum = {1'b0, score_q[4*i +: 4]} + {1'b0, add};
            dadj = dsum[3:0] - 4'd10;
            if (dsum > 5'd9) begin
                score_inc[4*i +: 4] = dadj;
                add = 4'd1;
            end else begin
                score_inc[4*i +: 4] = dsum[3:0];
                add = 4'd0;
            end
        end
        if (add != 4'd0) score_inc = {SCORE_DIGITS{4'h9}};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            log_q      <= 1'b0;
            pid_q      <= '0;
            guest_q    <= 1'b0;
            lvl_q      <= '0;
            score_q    <= '0;
            ind1_q     <= '0;
            ind2_q     <= '0;
            scram_q    <= 1'b0;
            flip_q     <= 1'b0;
            reconf_q   <= 1'b0;
            ten_q      <= 1'b0;
            new_high_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            log_q      <= log_d;
            pid_q      <= pid_d;
            guest_q    <= guest_d;
            lvl_q      <= lvl_d;
            score_q    <= score_d;
            ind1_q     <= ind1_d;
            ind2_q     <= ind2_d;
            scram_q    <= scram_d;
            flip_q     <= flip_d;
            reconf_q   <= reconf_d;
            ten_q      <= ten_d;
            new_high_q <= new_high_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        log_d      = log_q;
        pid_d      = pid_q;
        guest_d    = guest_q;
        lvl_d      = lvl_q;
        score_d    = score_q;
        ind1_d     = ind1_q;
        ind2_d     = ind2_q;
        scram_d    = 1'b0;
        flip_d     = 1'b0;
        reconf_d   = 1'b0;
        ten_d      = 1'b0;
        new_high_d = new_high_q;
`ifdef HIGH_SCORE_EN
        hs_wr      = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (logOn) begin
                    log_d   = 1'b1;
                    pid_d   = pIDin;
                    guest_d = isGuestIn;
                    state_d = S_MENU;
                end
            end
            S_MENU: begin
                if (pwdPls) begin
                    log_d      = 1'b0;
                    pid_d      = '0;
                    guest_d    = 1'b0;
                    lvl_d      = '0;
                    new_high_d = 1'b0;
                    state_d    = S_IDLE;
                end else if (startPls) begin
                    score_d    = '0;
                    new_high_d = 1'b0;
                    scram_d    = 1'b1;
                    reconf_d   = 1'b1;
                    state_d    = S_SCRAM;
                end else if (loadPls) begin
                    lvl_d = (lvl_q == 2'(LEVELS - 1)) ? 2'd0 : lvl_q + 2'd1;
                end
            end
            S_SCRAM: begin
                ten_d   = 1'b1;
                state_d = S_PLAY;
            end
            S_PLAY: begin
                ten_d = 1'b1;
                if (loadPls && (indIn1 != indIn2)) begin
                    ind1_d = indIn1;
                    ind2_d = indIn2;
                    flip_d = 1'b1;
                end
                if (isCorrect) score_d = score_inc;
                // Final score (including a same-cycle match) decides the high score.
                if (timeOut) begin
                    ten_d   = 1'b0;
                    state_d = S_OVER;
`ifdef HIGH_SCORE_EN
                    if (!guest_q && (score_d > hi_table[pid_q])) begin
                        hs_wr      = 1'b1;
                        new_high_d = 1'b1;
                    end
`endif
                end
            end
            S_OVER: begin
                if (pwdPls) begin
                    log_d      = 1'b0;
                    pid_d      = '0;
                    guest_d    = 1'b0;
                    lvl_d      = '0;
                    new_high_d = 1'b0;
                    state_d    = S_IDLE;
                end else if (startPls) begin
                    reconf_d   = 1'b1;
                    new_high_d = 1'b0;
                    state_d    = S_MENU;
                end
            end
            default: begin
                log_d      = 1'b0;
                pid_d      = '0;
                guest_d    = 1'b0;
                lvl_d      = '0;
                new_high_d = 1'b0;
                state_d    = S_IDLE;
            end
        endcase
    end

`ifdef HIGH_SCORE_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2**PID_W; i++) hi_table[i] <= '0;
        end else if (hs_wr) begin
            hi_table[pid_q] <= score_d;
        end
    end

    assign hiScore = log_q ? hi_table[pid_q] : '0;
`else
    assign hiScore = '0;
`endif

    assign state         = state_q;
    assign logOut        = log_q;
    assign pIDout        = pid_q;
    assign isGuestOut    = guest_q;
    assign score         = score_q;
    assign lvl           = lvl_q;
    assign scramPls      = scram_q;
    assign flipPls       = flip_q;
    assign timerReconfig = reconf_q;
    assign indOut1       = ind1_q;
    assign indOut2       = ind2_q;
    assign timerEn       = ten_q;
    assign newHigh       = new_high_q;

endmodule
